rob_superscalar: RTL and testbench

Parametrised N-way reorder buffer for the out-of-order core: a circular buffer of in-flight instructions between dispatch and retire. Per cycle it accepts up to DISPATCH_W instructions in program order, marks completions from CDB_W broadcast ports, and retires up to RETIRE_W oldest completed entries. Retirement drives the arch map and free-list updates. On branch squash it rolls the tail back and reports the squashed destination physical registers as a one-hot mask for the free list.

---
 rtl/rob_superscalar.sv | 166 ++++++++++++++++
 tb/tb_rob_superscalar.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_superscalar.sv
// Circular reorder buffer that dispatches up to DISPATCH_W ops in order, marks completions from the CDB,
// retires up to RETIRE_W oldest done entries, and rolls the tail back on a branch squash.
module rob_superscalar #(
  parameter int ROB_DEPTH  = 32,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int CDB_W      = 2,
  parameter int PREG_W     = 6,
  parameter int AREG_W     = 5,
  parameter int PC_W       = 32,
  parameter int IDX_W      = $clog2(ROB_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DISPATCH_W-1:0]        dispatch_valid,
  input  logic [DISPATCH_W*AREG_W-1:0] dispatch_areg,
  input  logic [DISPATCH_W*PREG_W-1:0] dispatch_T,
  input  logic [DISPATCH_W*PREG_W-1:0] dispatch_Told,
  input  logic [DISPATCH_W*PC_W-1:0]   dispatch_pc,
  output logic                         dispatch_accept,
  output logic [DISPATCH_W*IDX_W-1:0]  dispatch_idx,
  output logic [IDX_W:0]               free_slots,
  input  logic [CDB_W-1:0]             complete_valid,
  input  logic [CDB_W*IDX_W-1:0]       complete_idx,
  output logic [RETIRE_W-1:0]          retire_valid,
  output logic [RETIRE_W*AREG_W-1:0]   retire_areg,
  output logic [RETIRE_W*PREG_W-1:0]   retire_T,
  output logic [RETIRE_W-1:0]          retire_free_valid,
  output logic [RETIRE_W*PREG_W-1:0]   retire_Told,
  output logic [RETIRE_W*PC_W-1:0]     retire_pc,
  input  logic                         squash_valid,
  input  logic [IDX_W-1:0]             squash_idx,
  output logic [(1<<PREG_W)-1:0]       rollback_mask,
  output logic [IDX_W-1:0]             head,
  output logic [IDX_W:0]               count,
  output logic                         full,
  output logic                         empty
);
  localparam int CW = IDX_W + 1;

  logic [ROB_DEPTH-1:0] ent_valid;
  logic [ROB_DEPTH-1:0] ent_done;
  logic [AREG_W-1:0]    ent_areg [ROB_DEPTH];
  logic [PREG_W-1:0]    ent_t    [ROB_DEPTH];
  logic [PREG_W-1:0]    ent_told [ROB_DEPTH];
  logic [PC_W-1:0]      ent_pc   [ROB_DEPTH];

  logic [IDX_W-1:0]     tail;
  logic [CW-1:0]        disp_n;
  logic [CW-1:0]        ret_n;
  logic [IDX_W-1:0]     keep_span;
  logic [ROB_DEPTH-1:0] squashed;
  logic                 dispatch_go;
  logic                 ret_ok;

  assign free_slots  = CW'(ROB_DEPTH) - count;
  assign full        = (count == CW'(ROB_DEPTH));
  assign empty       = (count == '0);
  // Offset of the branch from head: entries at offsets above this are flushed.
  assign keep_span   = squash_idx - head;
  assign dispatch_go = (disp_n <= free_slots) && !squash_valid;
  assign dispatch_accept = dispatch_go;

  always_comb begin
    disp_n = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_n = disp_n + CW'(dispatch_valid[k]);
      dispatch_idx[k*IDX_W +: IDX_W] = tail + IDX_W'(k);
    end
  end

  // Retirement never reaches past the squashing branch, keeping the rollback count non-negative.
  always_comb begin
    ret_ok            = 1'b1;
    ret_n             = '0;
    retire_valid      = '0;
    retire_free_valid = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_ok = ret_ok && ent_valid[head + IDX_W'(k)] && ent_done[head + IDX_W'(k)]
               && (!squash_valid || (IDX_W'(k) <= keep_span));
      retire_valid[k]      = ret_ok;
      retire_free_valid[k] = ret_ok && (ent_areg[head + IDX_W'(k)] != '0);
      ret_n                = ret_n + CW'(ret_ok);
      retire_areg[k*AREG_W +: AREG_W] = ent_areg[head + IDX_W'(k)];
      retire_T[k*PREG_W +: PREG_W]    = ent_t[head + IDX_W'(k)];
      retire_Told[k*PREG_W +: PREG_W] = ent_told[head + IDX_W'(k)];
      retire_pc[k*PC_W +: PC_W]       = ent_pc[head + IDX_W'(k)];
    end
  end

  always_comb begin
    squashed      = '0;
    rollback_mask = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      squashed[i] = squash_valid && ent_valid[i] && (IDX_W'(IDX_W'(i) - head) > keep_span);
      if (squashed[i] && (ent_areg[i] != '0)) begin
        rollback_mask[ent_t[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (dispatch_go) begin
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (dispatch_valid[k]) begin
          ent_areg[tail + IDX_W'(k)] <= dispatch_areg[k*AREG_W +: AREG_W];
          ent_t[tail + IDX_W'(k)]    <= dispatch_T[k*PREG_W +: PREG_W];
          ent_told[tail + IDX_W'(k)] <= dispatch_Told[k*PREG_W +: PREG_W];
          ent_pc[tail + IDX_W'(k)]   <= dispatch_pc[k*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      // Dispatch only ever writes free slots, so it cannot collide with retire or completion.
      if (dispatch_go) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (dispatch_valid[k]) begin
            ent_valid[tail + IDX_W'(k)] <= 1'b1;
            ent_done[tail + IDX_W'(k)]  <= 1'b0;
          end
        end
      end
      for (int c = 0; c < CDB_W; c++) begin
        if (complete_valid[c] && ent_valid[complete_idx[c*IDX_W +: IDX_W]]) begin
          ent_done[complete_idx[c*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (retire_valid[k]) begin
          ent_valid[head + IDX_W'(k)] <= 1'b0;
          ent_done[head + IDX_W'(k)]  <= 1'b0;
        end
      end
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (squashed[i]) begin
          ent_valid[i] <= 1'b0;
          ent_done[i]  <= 1'b0;
        end
      end

      head <= head + IDX_W'(ret_n);
      if (squash_valid) begin
        tail  <= squash_idx + IDX_W'(1);
        count <= CW'(keep_span) + CW'(1) - ret_n;
      end else begin
        tail  <= tail + (dispatch_go ? IDX_W'(disp_n) : '0);
        count <= count + (dispatch_go ? disp_n : '0) - ret_n;
      end

      assert (count <= CW'(ROB_DEPTH));
      assert ((retire_valid & (retire_valid + RETIRE_W'(1))) == '0);
      assert ((dispatch_valid & (dispatch_valid + DISPATCH_W'(1))) == '0);
      assert (!squash_valid || ent_valid[squash_idx]);
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed plus random checking of rob_superscalar against a program-order queue model of in-flight instructions.
module tb_rob_superscalar;
  localparam int D = 32;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  dispatch_valid;
  logic [9:0]  dispatch_areg;
  logic [11:0] dispatch_T, dispatch_Told;
  logic [63:0] dispatch_pc;
  logic        dispatch_accept;
  logic [9:0]  dispatch_idx;
  logic [5:0]  free_slots;
  logic [1:0]  complete_valid;
  logic [9:0]  complete_idx;
  logic [1:0]  retire_valid, retire_free_valid;
  logic [9:0]  retire_areg;
  logic [11:0] retire_T, retire_Told;
  logic [63:0] retire_pc;
  logic        squash_valid;
  logic [4:0]  squash_idx;
  logic [63:0] rollback_mask;
  logic [4:0]  head;
  logic [5:0]  count;
  logic        full, empty;

  rob_superscalar dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_areg(dispatch_areg), .dispatch_T(dispatch_T),
    .dispatch_Told(dispatch_Told), .dispatch_pc(dispatch_pc), .dispatch_accept(dispatch_accept),
    .dispatch_idx(dispatch_idx), .free_slots(free_slots),
    .complete_valid(complete_valid), .complete_idx(complete_idx),
    .retire_valid(retire_valid), .retire_areg(retire_areg), .retire_T(retire_T),
    .retire_free_valid(retire_free_valid), .retire_Told(retire_Told), .retire_pc(retire_pc),
    .squash_valid(squash_valid), .squash_idx(squash_idx), .rollback_mask(rollback_mask),
    .head(head), .count(count), .full(full), .empty(empty)
  );

  // Stimulus variables for the current cycle.
  logic        rst;
  logic [1:0]  dv, cv;
  logic [4:0]  d_areg [2];
  logic [5:0]  d_t [2];
  logic [5:0]  d_told [2];
  logic [31:0] d_pc [2];
  logic [4:0]  c_idx [2];
  logic        sq;
  logic [4:0]  sq_idx;
  bit          areg_mode;

  typedef struct {
    int          idx;
    int          areg;
    int          t;
    int          told;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  ent_t q[$];
  int   head_m, tail_m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    reset          = rst;
    dispatch_valid = dv;
    complete_valid = cv;
    squash_valid   = sq;
    squash_idx     = sq_idx;
    for (int k = 0; k < 2; k++) begin
      dispatch_areg[k*5 +: 5]  = d_areg[k];
      dispatch_T[k*6 +: 6]     = d_t[k];
      dispatch_Told[k*6 +: 6]  = d_told[k];
      dispatch_pc[k*32 +: 32]  = d_pc[k];
      complete_idx[k*5 +: 5]   = c_idx[k];
    end
  endtask

  // Position of the squashing branch in program order; D means no squash.
  function automatic int sq_pos();
    if (!sq) return D;
    foreach (q[j]) if (q[j].idx == int'(sq_idx)) return j;
    return -1;
  endfunction

  function automatic int calc_r();
    int lim = sq_pos();
    int r = 0;
    while (r < 2 && r < q.size() && q[r].done && r <= lim) r++;
    return r;
  endfunction

  function automatic int t_of(input int idx);
    if (idx == 31) return 40;
    if (idx <= 3) return 41 + idx;
    return idx;
  endfunction

  task automatic set_disp(input int nl);
    dv = (nl == 2) ? 2'b11 : (nl == 1) ? 2'b01 : 2'b00;
    for (int k = 0; k < 2; k++) begin
      int idx = (tail_m + k) % D;
      d_areg[k] = areg_mode ? 5'((idx % 8) | 1) : 5'(idx % 8);
      d_t[k]    = 6'(t_of(idx));
      d_told[k] = 6'((idx + 12) % 64);
      d_pc[k]   = 32'h1000 + 32'(idx * 4);
    end
  endtask

  task automatic check_all();
    int n, r, pos;
    logic [63:0] m;
    logic [1:0] erv, efv;
    n = int'(dv[0]) + int'(dv[1]);
    chk("dispatch_accept", 64'(dispatch_accept), 64'((n <= D - q.size()) && !sq));
    for (int k = 0; k < 2; k++) chk("dispatch_idx", 64'(dispatch_idx[k*5 +: 5]), 64'((tail_m + k) % D));
    chk("free_slots", 64'(free_slots), 64'(D - q.size()));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == D));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("head", 64'(head), 64'(head_m));
    r = calc_r();
    erv = '0;
    efv = '0;
    for (int k = 0; k < r; k++) begin
      erv[k] = 1'b1;
      efv[k] = (q[k].areg != 0);
      chk("retire_areg", 64'(retire_areg[k*5 +: 5]), 64'(q[k].areg));
      chk("retire_T", 64'(retire_T[k*6 +: 6]), 64'(q[k].t));
      chk("retire_Told", 64'(retire_Told[k*6 +: 6]), 64'(q[k].told));
      chk("retire_pc", 64'(retire_pc[k*32 +: 32]), 64'(q[k].pc));
    end
    chk("retire_valid", 64'(retire_valid), 64'(erv));
    chk("retire_free_valid", 64'(retire_free_valid), 64'(efv));
    m = '0;
    pos = sq_pos();
    if (sq) for (int j = pos + 1; j < q.size(); j++) if (q[j].areg != 0) m[q[j].t] = 1'b1;
    chk("rollback_mask", rollback_mask, m);
  endtask

  task automatic model_update();
    int r, pos, n;
    if (rst) begin
      q.delete();
      head_m = 0;
      tail_m = 0;
      return;
    end
    r   = calc_r();
    pos = sq_pos();
    n   = int'(dv[0]) + int'(dv[1]);
    for (int c = 0; c < 2; c++)
      if (cv[c]) foreach (q[j]) if (q[j].idx == int'(c_idx[c])) q[j].done = 1'b1;
    for (int k = 0; k < r; k++) begin
      void'(q.pop_front());
      head_m = (head_m + 1) % D;
    end
    if (sq) begin
      while (q.size() > pos + 1 - r) void'(q.pop_back());
      tail_m = (int'(sq_idx) + 1) % D;
    end else if (n <= D - (q.size() + r)) begin
      for (int k = 0; k < n; k++) begin
        ent_t e;
        e.idx = tail_m; e.areg = int'(d_areg[k]); e.t = int'(d_t[k]);
        e.told = int'(d_told[k]); e.pc = d_pc[k]; e.done = 1'b0;
        q.push_back(e);
        tail_m = (tail_m + 1) % D;
      end
    end
  endtask

  task automatic run_cycle();
    drive();
    @(negedge clock);
    if (!rst) check_all();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  initial begin
    rst = 1'b1; dv = '0; cv = '0; sq = 1'b0; sq_idx = '0; areg_mode = 1'b0;
    head_m = 0; tail_m = 0;
    for (int k = 0; k < 2; k++) begin
      d_areg[k] = '0; d_t[k] = '0; d_told[k] = '0; d_pc[k] = '0; c_idx[k] = '0;
    end
    run_cycle();
    rst = 1'b0;
    settle();
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_free_slots", 64'(free_slots), 64'd32);
    chk("reset_retire_valid", 64'(retire_valid), 64'd0);
    chk("reset_rollback_mask", rollback_mask, 64'd0);
    chk("reset_accept", 64'(dispatch_accept), 64'd1);

    // Fill to full, then one stalled attempt.
    for (int i = 0; i < 16; i++) begin set_disp(2); run_cycle(); end
    set_disp(2); run_cycle();
    chk("fill_accept_stall", 64'(dispatch_accept), 64'd0);
    chk("fill_count", 64'(count), 64'd32);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_idx_wrap", 64'(dispatch_idx[4:0]), 64'd0);

    // Out-of-order completion and in-order retire; dispatch stays blocked while full.
    dv = '0; cv = 2'b11; c_idx[0] = 5'd1; c_idx[1] = 5'd0; run_cycle();
    cv = '0; set_disp(2); settle();
    chk("retire_pair", 64'(retire_valid), 64'b11);
    chk("retire_zero_reg", 64'(retire_free_valid), 64'b10);
    chk("retire_told_1", 64'(retire_Told[11:6]), 64'd13);
    chk("full_retire_accept", 64'(dispatch_accept), 64'd0);
    run_cycle();
    dv = '0; cv = 2'b01; c_idx[0] = 5'd3; run_cycle();
    cv = '0; settle();
    chk("retire_blocked", 64'(retire_valid), 64'b00);
    run_cycle();
    cv = 2'b01; c_idx[0] = 5'd2; run_cycle();
    cv = '0; settle();
    chk("retire_unblocked", 64'(retire_valid), 64'b11);
    run_cycle();
    cv = 2'b11; c_idx[0] = 5'd4; c_idx[1] = 5'd5; run_cycle();
    cv = '0; settle();
    chk("retire_free_areg5", 64'(retire_free_valid), 64'b11);
    chk("retire_areg5", 64'(retire_areg[9:5]), 64'd5);
    chk("retire_told17", 64'(retire_Told[11:6]), 64'd17);
    run_cycle();

    // Wrapped squash: head=28, tail=4, branch at 30.
    rst = 1'b1; run_cycle(); rst = 1'b0; areg_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin set_disp(2); run_cycle(); end
    dv = '0;
    for (int i = 0; i < 14; i++) begin
      cv = 2'b11; c_idx[0] = 5'(2 * i); c_idx[1] = 5'(2 * i + 1); run_cycle();
    end
    cv = '0; run_cycle();
    for (int i = 0; i < 4; i++) begin set_disp(2); run_cycle(); end
    dv = '0; settle();
    chk("wrap_head", 64'(head), 64'd28);
    chk("wrap_count", 64'(count), 64'd8);
    sq = 1'b1; sq_idx = 5'd30; settle();
    chk("wrap_rollback", rollback_mask, 64'h0000_1F00_0000_0000);
    run_cycle();
    sq = 1'b0; settle();
    chk("squash_count", 64'(count), 64'd3);
    chk("squash_tail", 64'(dispatch_idx[4:0]), 64'd31);

    // Squash with dispatch pending and two retiring; then a stale completion.
    set_disp(2); run_cycle();
    set_disp(1); run_cycle();
    dv = '0; cv = 2'b11; c_idx[0] = 5'd28; c_idx[1] = 5'd29; run_cycle();
    cv = '0; sq = 1'b1; sq_idx = 5'd30; set_disp(2); settle();
    chk("sq_retire", 64'(retire_valid), 64'b11);
    chk("sq_accept", 64'(dispatch_accept), 64'd0);
    run_cycle();
    sq = 1'b0; dv = '0; settle();
    chk("sq_head", 64'(head), 64'd30);
    chk("sq_count", 64'(count), 64'd1);
    cv = 2'b01; c_idx[0] = 5'd31; set_disp(1); run_cycle();
    dv = '0; cv = 2'b01; c_idx[0] = 5'd30; run_cycle();
    cv = '0; settle();
    chk("stale_complete", 64'(retire_valid), 64'b01);
    run_cycle();

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 599) == 0);
      case ($urandom_range(0, 2))
        0: dv = 2'b00;
        1: dv = 2'b01;
        default: dv = 2'b11;
      endcase
      for (int k = 0; k < 2; k++) begin
        d_areg[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        d_t[k]    = 6'($urandom_range(0, 63));
        d_told[k] = 6'($urandom_range(0, 63));
        d_pc[k]   = $urandom;
        cv[k]     = 1'($urandom_range(0, 1));
        c_idx[k]  = (q.size() > 0 && $urandom_range(0, 3) != 0)
                    ? 5'(q[$urandom_range(0, q.size() - 1)].idx) : 5'($urandom_range(0, 31));
      end
      sq = (q.size() > 0) && ($urandom_range(0, 15) == 0);
      if (sq) sq_idx = 5'(q[$urandom_range(0, q.size() - 1)].idx);
      run_cycle();
    end

    // Reset while full with a squash pending.
    rst = 1'b1; sq = 1'b0; cv = '0; dv = '0; run_cycle(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin set_disp(2); run_cycle(); end
    rst = 1'b1; sq = 1'b1; sq_idx = 5'd5; cv = 2'b11; c_idx[0] = 5'd0; c_idx[1] = 5'd1;
    set_disp(2); run_cycle();
    rst = 1'b0; sq = 1'b0; dv = '0; cv = '0; settle();
    chk("rst_full_empty", 64'(empty), 64'd1);
    chk("rst_full_free", 64'(free_slots), 64'd32);
    chk("rst_full_mask", rollback_mask, 64'd0);
    chk("rst_full_count", 64'(count), 64'd0);
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
